// File: rtl/c2c_mem_arbiter.sv
// c2c_mem_arbiter: merges the core's instruction-read, data-read and
// data-write c2c masters onto one single-ported memory slave port.
// Accesses are serialised, read data and acks are steered back to the
// originating master, instruction fetch alternates with data traffic under
// contention, and stale (registered) requests are masked after each ack.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   instr_re/sel/addr -> instr_ack/data  instruction read master
//   dr_re/sel/addr    -> dr_ack/data     data read master
//   dw_we/sel/addr/data -> dw_ack        data write master
//   mem_req/we/sel/addr/wdata            memory request (held until mem_ack)
//   mem_ack, mem_rdata                   memory completion pulse and read data
module c2c_mem_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MASK_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_re,
  input  logic [XLEN/8-1:0] instr_sel,
  input  logic [XLEN-1:0]   instr_addr,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic              dr_re,
  input  logic [XLEN/8-1:0] dr_sel,
  input  logic [XLEN-1:0]   dr_addr,
  output logic              dr_ack,
  output logic [XLEN-1:0]   dr_data,
  input  logic              dw_we,
  input  logic [XLEN/8-1:0] dw_sel,
  input  logic [XLEN-1:0]   dw_addr,
  input  logic [XLEN-1:0]   dw_data,
  output logic              dw_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned  SELW      = XLEN / 8;
  localparam int unsigned  MW        = $clog2(MASK_CYC + 1);
  localparam logic [MW-1:0] MASK_LOAD = MW'(MASK_CYC);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_I  = 2'd1;
  localparam logic [1:0] S_BUSY_DR = 2'd2;
  localparam logic [1:0] S_BUSY_DW = 2'd3;

  logic [1:0]      r_state;
  logic            r_last_instr;
  logic [MW-1:0]   r_mask_i;
  logic [MW-1:0]   r_mask_dr;
  logic [MW-1:0]   r_mask_dw;
  logic            r_instr_ack;
  logic [31:0]     r_instr_data;
  logic            r_dr_ack;
  logic [XLEN-1:0] r_dr_data;
  logic            r_dw_ack;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [SELW-1:0] r_mem_sel;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;

  logic [1:0] w_state_nxt;
  logic       w_elig_i, w_elig_dr, w_elig_dw;
  logic       w_gnt_i, w_gnt_dr, w_gnt_dw;
  logic       w_done_i, w_done_dr, w_done_dw;

  // A request only counts once its post-ack mask window has expired
  assign w_elig_i  = instr_re && (r_mask_i  == '0);
  assign w_elig_dr = dr_re    && (r_mask_dr == '0);
  assign w_elig_dw = dw_we    && (r_mask_dw == '0);

  // Next-state, grant and completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_dr    = 1'b0;
    w_gnt_dw    = 1'b0;
    w_done_i    = 1'b0;
    w_done_dr   = 1'b0;
    w_done_dw   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Fetch first unless it won last time; then write beats read
        if (w_elig_i && !r_last_instr) begin
          w_gnt_i     = 1'b1;
          w_state_nxt = S_BUSY_I;
        end else if (w_elig_dw) begin
          w_gnt_dw    = 1'b1;
          w_state_nxt = S_BUSY_DW;
        end else if (w_elig_dr) begin
          w_gnt_dr    = 1'b1;
          w_state_nxt = S_BUSY_DR;
        end else if (w_elig_i) begin
          w_gnt_i     = 1'b1;
          w_state_nxt = S_BUSY_I;
        end
      end
      S_BUSY_I: begin
        if (mem_ack) begin
          w_done_i    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY_DR: begin
        if (mem_ack) begin
          w_done_dr   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY_DW: begin
        if (mem_ack) begin
          w_done_dw   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, memory-side request and upstream response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_instr <= 1'b0;
      r_mask_i     <= '0;
      r_mask_dr    <= '0;
      r_mask_dw    <= '0;
      r_instr_ack  <= 1'b0;
      r_instr_data <= '0;
      r_dr_ack     <= 1'b0;
      r_dr_data    <= '0;
      r_dw_ack     <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_sel    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_instr_ack <= w_done_i;
      r_dr_ack    <= w_done_dr;
      r_dw_ack    <= w_done_dw;

      if (w_gnt_i) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_sel    <= instr_sel;
        r_mem_addr   <= instr_addr;
        r_mem_wdata  <= '0;
        r_last_instr <= 1'b1;
      end
      if (w_gnt_dr) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_sel    <= dr_sel;
        r_mem_addr   <= dr_addr;
        r_mem_wdata  <= '0;
        r_last_instr <= 1'b0;
      end
      if (w_gnt_dw) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b1;
        r_mem_sel    <= dw_sel;
        r_mem_addr   <= dw_addr;
        r_mem_wdata  <= dw_data;
        r_last_instr <= 1'b0;
      end

      if (w_done_i || w_done_dr || w_done_dw) r_mem_req <= 1'b0;
      if (w_done_i)  r_instr_data <= mem_rdata[31:0];
      if (w_done_dr) r_dr_data    <= mem_rdata;

      // Mask counters load as the ack goes out, then count down to zero
      if (w_done_i)               r_mask_i <= MASK_LOAD;
      else if (r_mask_i != '0)    r_mask_i <= r_mask_i - MW'(1);
      if (w_done_dr)              r_mask_dr <= MASK_LOAD;
      else if (r_mask_dr != '0)   r_mask_dr <= r_mask_dr - MW'(1);
      if (w_done_dw)              r_mask_dw <= MASK_LOAD;
      else if (r_mask_dw != '0)   r_mask_dw <= r_mask_dw - MW'(1);
    end
  end

  assign instr_ack  = r_instr_ack;
  assign instr_data = r_instr_data;
  assign dr_ack     = r_dr_ack;
  assign dr_data    = r_dr_data;
  assign dw_ack     = r_dw_ack;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_sel    = r_mem_sel;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_c2c_mem_arbiter.sv
// Directed bench for c2c_mem_arbiter: a per-cycle vector table for single
// accesses and write/read contention, plus hand-written sequences for
// fetch/data alternation, stale-request masking and async reset.
module tb_c2c_mem_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SELW = XLEN / 8;

  localparam logic [31:0] A_I  = 32'h0000_0100;
  localparam logic [31:0] A_DW = 32'h0000_0200;
  localparam logic [31:0] A_DR = 32'h0000_0204;
  localparam logic [31:0] D_DW = 32'hDEAD_BEEF;
  localparam logic [3:0]  S_I  = 4'hF;
  localparam logic [3:0]  S_DR = 4'h3;
  localparam logic [3:0]  S_DW = 4'hF;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            instr_re;
  logic [SELW-1:0] instr_sel;
  logic [XLEN-1:0] instr_addr;
  logic            instr_ack;
  logic [31:0]     instr_data;
  logic            dr_re;
  logic [SELW-1:0] dr_sel;
  logic [XLEN-1:0] dr_addr;
  logic            dr_ack;
  logic [XLEN-1:0] dr_data;
  logic            dw_we;
  logic [SELW-1:0] dw_sel;
  logic [XLEN-1:0] dw_addr;
  logic [XLEN-1:0] dw_data;
  logic            dw_ack;
  logic            mem_req;
  logic            mem_we;
  logic [SELW-1:0] mem_sel;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  c2c_mem_arbiter #(.XLEN(XLEN), .MASK_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data),
    .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr),
    .dr_ack(dr_ack), .dr_data(dr_data),
    .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data),
    .dw_ack(dw_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // One row: inputs held for a cycle, outputs expected after that edge
  typedef struct {
    string       name;
    logic        ire, dre, dwe, mack;
    logic [31:0] rdata;
    logic        mreq, mwe;
    logic [31:0] maddr;
    logic [3:0]  msel;
    logic [31:0] mwdata;
    logic        iack, drack, dwack;
    logic [31:0] idata, drdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic ire, input logic dre,
                     input logic dwe, input logic mack, input logic [31:0] rdata,
                     input logic mreq, input logic mwe, input logic [31:0] maddr,
                     input logic [3:0] msel, input logic [31:0] mwdata,
                     input logic iack, input logic drack, input logic dwack,
                     input logic [31:0] idata, input logic [31:0] drdata);
    vec_t v;
    v.name = name; v.ire = ire; v.dre = dre; v.dwe = dwe; v.mack = mack;
    v.rdata = rdata; v.mreq = mreq; v.mwe = mwe; v.maddr = maddr;
    v.msel = msel; v.mwdata = mwdata; v.iack = iack; v.drack = drack;
    v.dwack = dwack; v.idata = idata; v.drdata = drdata;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'h0);
    check({tag, "_mem_we"},     32'(mem_we),     32'h0);
    check({tag, "_mem_sel"},    32'(mem_sel),    32'h0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  32'h0);
    check({tag, "_instr_ack"},  32'(instr_ack),  32'h0);
    check({tag, "_instr_data"}, 32'(instr_data), 32'h0);
    check({tag, "_dr_ack"},     32'(dr_ack),     32'h0);
    check({tag, "_dr_data"},    32'(dr_data),    32'h0);
    check({tag, "_dw_ack"},     32'(dw_ack),     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_order [8];
    int          n_grants;
    int          dw_hold;
    int          dr_hold;
    logic        prev_req;

    reset_n    = 1'b0;
    instr_re   = 1'b0; instr_sel = S_I;  instr_addr = A_I;
    dr_re      = 1'b0; dr_sel    = S_DR; dr_addr    = A_DR;
    dw_we      = 1'b0; dw_sel    = S_DW; dw_addr    = A_DW; dw_data = D_DW;
    mem_ack    = 1'b0; mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    //   name        ire dre dwe mack rdata         mreq we maddr msel mwdata  iack drack dwack idata         drdata
    add("i_grant",   1, 0, 0, 0, 32'h0,           1, 0, A_I,  S_I,  32'h0, 0, 0, 0, 32'h0,         32'h0);
    add("i_wait1",   1, 0, 0, 0, 32'h0,           1, 0, A_I,  S_I,  32'h0, 0, 0, 0, 32'h0,         32'h0);
    add("i_wait2",   1, 0, 0, 0, 32'h0,           1, 0, A_I,  S_I,  32'h0, 0, 0, 0, 32'h0,         32'h0);
    add("i_done",    1, 0, 0, 1, 32'h0050_0093,   0, 0, A_I,  S_I,  32'h0, 1, 0, 0, 32'h0050_0093, 32'h0);
    add("i_stale",   1, 0, 0, 0, 32'h0,           0, 0, A_I,  S_I,  32'h0, 0, 0, 0, 32'h0050_0093, 32'h0);
    add("i_idle",    0, 0, 0, 0, 32'h0,           0, 0, A_I,  S_I,  32'h0, 0, 0, 0, 32'h0050_0093, 32'h0);
    add("dw_first",  0, 1, 1, 0, 32'h0,           1, 1, A_DW, S_DW, D_DW,  0, 0, 0, 32'h0050_0093, 32'h0);
    add("dw_done",   0, 1, 1, 1, 32'h1111_1111,   0, 0, A_DW, S_DW, D_DW,  0, 0, 1, 32'h0050_0093, 32'h0);
    add("dr_next",   0, 1, 1, 0, 32'h0,           1, 0, A_DR, S_DR, 32'h0, 0, 0, 0, 32'h0050_0093, 32'h0);
    add("dr_done",   0, 1, 0, 1, 32'h1234_5678,   0, 0, A_DR, S_DR, 32'h0, 0, 1, 0, 32'h0050_0093, 32'h1234_5678);
    add("dr_stale",  0, 1, 0, 0, 32'h0,           0, 0, A_DR, S_DR, 32'h0, 0, 0, 0, 32'h0050_0093, 32'h1234_5678);
    add("idle",      0, 0, 0, 0, 32'h0,           0, 0, A_DR, S_DR, 32'h0, 0, 0, 0, 32'h0050_0093, 32'h1234_5678);
    add("spurious",  0, 0, 0, 1, 32'hFFFF_FFFF,   0, 0, A_DR, S_DR, 32'h0, 0, 0, 0, 32'h0050_0093, 32'h1234_5678);

    foreach (vecs[i]) begin
      @(negedge clk);
      instr_re  = vecs[i].ire;
      dr_re     = vecs[i].dre;
      dw_we     = vecs[i].dwe;
      mem_ack   = vecs[i].mack;
      mem_rdata = vecs[i].rdata;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_mem_req"},    32'(mem_req),    32'(vecs[i].mreq));
      check({vecs[i].name, "_instr_ack"},  32'(instr_ack),  32'(vecs[i].iack));
      check({vecs[i].name, "_dr_ack"},     32'(dr_ack),     32'(vecs[i].drack));
      check({vecs[i].name, "_dw_ack"},     32'(dw_ack),     32'(vecs[i].dwack));
      check({vecs[i].name, "_instr_data"}, instr_data,      vecs[i].idata);
      check({vecs[i].name, "_dr_data"},    dr_data,         vecs[i].drdata);
      if (vecs[i].mreq) begin
        check({vecs[i].name, "_mem_we"},    32'(mem_we),   32'(vecs[i].mwe));
        check({vecs[i].name, "_mem_addr"},  mem_addr,      vecs[i].maddr);
        check({vecs[i].name, "_mem_sel"},   32'(mem_sel),  32'(vecs[i].msel));
        check({vecs[i].name, "_mem_wdata"}, mem_wdata,     vecs[i].mwdata);
      end
    end

    // Alternation: fetch held, data masters drop for 4 cycles after each ack
    exp_order[0] = A_I; exp_order[1] = A_DW; exp_order[2] = A_I; exp_order[3] = A_DR;
    exp_order[4] = A_I; exp_order[5] = A_DW; exp_order[6] = A_I; exp_order[7] = A_DR;
    n_grants = 0; dw_hold = 0; dr_hold = 0; prev_req = 1'b0;
    for (int cyc = 0; cyc < 80 && n_grants < 8; cyc++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        check($sformatf("fair_grant%0d_addr", n_grants), mem_addr, exp_order[n_grants]);
        check($sformatf("fair_grant%0d_we", n_grants), 32'(mem_we),
              32'(exp_order[n_grants] == A_DW));
        n_grants++;
      end
      prev_req = mem_req;
      mem_ack  = mem_req;
      mem_rdata = 32'hCAFE_0000 + 32'(cyc);
      instr_re = 1'b1;
      if (dw_ack) begin dw_hold = 3; dw_we = 1'b0; end
      else if (dw_hold > 0) begin dw_hold--; dw_we = 1'b0; end
      else dw_we = 1'b1;
      if (dr_ack) begin dr_hold = 3; dr_re = 1'b0; end
      else if (dr_hold > 0) begin dr_hold--; dr_re = 1'b0; end
      else dr_re = 1'b1;
    end
    check("fair_grant_count", 32'(n_grants), 32'd8);
    @(negedge clk);
    instr_re = 1'b0; dr_re = 1'b0; dw_we = 1'b0; mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("fair_drained_req", 32'(mem_req), 32'h0);

    // Stale mask: dr_re held through ack; masked two cycles, granted on third
    dr_re = 1'b1;
    @(negedge clk);
    check("mask_first_req", 32'(mem_req), 32'h1);
    check("mask_first_addr", mem_addr, A_DR);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mem_ack = 1'b0;
    check("mask_ack", 32'(dr_ack), 32'h1);
    check("mask_data", dr_data, 32'hA5A5_A5A5);
    check("mask_c1_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    check("mask_c2_req", 32'(mem_req), 32'h0);
    check("mask_c2_ack", 32'(dr_ack), 32'h0);
    @(negedge clk);
    check("mask_c3_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    check("mask_regrant_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A; dr_re = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("mask_second_ack", 32'(dr_ack), 32'h1);
    check("mask_second_data", dr_data, 32'h5A5A_5A5A);
    repeat (3) @(negedge clk);

    // Async reset with a fetch in flight, then a late mem_ack
    instr_re = 1'b1;
    @(negedge clk);
    check("rst_inflight_req", 32'(mem_req), 32'h1);
    instr_re = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk);
    #1;
    check("late_ack_instr_ack", 32'(instr_ack), 32'h0);
    check("late_ack_mem_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("late_ack_instr_ack2", 32'(instr_ack), 32'h0);
    check("late_ack_instr_data", instr_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
